// File: rtl/muldiv_sequencer_pkg.sv
// Shared types, widths and helpers for the RV32M multiply/divide sequencer.
package muldiv_sequencer_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = $clog2(XLEN) + 1;

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } md_op_e;

    typedef enum logic [2:0] {
        MD_IDLE = 3'd0,
        MD_MUL  = 3'd1,
        MD_DIV  = 3'd2,
        MD_FIX  = 3'd3,
        MD_DONE = 3'd4
    } md_state_e;

    // Per-operation context captured when an op is accepted.
    typedef struct packed {
        md_op_e op;
        logic   neg_q;
        logic   neg_r;
        logic   div0;
        logic   ovf;
    } md_ctx_t;

    function automatic logic op_signed_a(input md_op_e op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_signed_b(input md_op_e op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    // Architectural result for divide-by-zero (div0=1) or signed overflow (div0=0).
    function automatic logic [XLEN-1:0] md_special(input md_op_e op, input logic div0,
                                                   input logic [XLEN-1:0] a);
        if (div0) return op[1] ? a : '1;
        return op[1] ? '0 : INT_MIN;
    endfunction

endpackage

// File: rtl/muldiv_sequencer_datapath.sv
// Operand conditioning, shift-add / restoring-divide iteration, sign fixup and result register.
// MULDIV_FAST_PATH_EN: divide-by-zero, signed overflow and MUL-by-zero resolved at accept.
module muldiv_sequencer_datapath
    import muldiv_sequencer_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            accept,
    input  logic            step,
    input  logic            fix,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            fast,
    output logic [XLEN-1:0] result
);

    md_op_e            op_in;
    logic              sa, sb, div0, ovf;
    logic [XLEN-1:0]   abs_a, abs_b;
    md_ctx_t           ctx;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   opb;
    logic [XLEN-1:0]   src_a;

    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     div_hi;
    logic              div_ge;
    logic [XLEN-1:0]   div_diff;
    logic [2*XLEN-1:0] div_next;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, fix_val;

    // Operand decode for the op being offered this cycle.
    always_comb begin
        op_in = md_op_e'(op);
        sa    = op_signed_a(op_in) & rs1[XLEN-1];
        sb    = op_signed_b(op_in) & rs2[XLEN-1];
        abs_a = sa ? -rs1 : rs1;
        abs_b = sb ? -rs2 : rs2;
        div0  = op[2] & (rs2 == '0);
        ovf   = ((op_in == OP_DIV) || (op_in == OP_REM)) && (rs1 == INT_MIN) && (rs2 == '1);
    end

    // One multiply or divide bit per step; acc holds {hi, lo} = {rem, quot} for divides.
    always_comb begin
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, opb};
        mul_next = acc[0] ? {mul_sum, acc[XLEN-1:1]} : {1'b0, acc[2*XLEN-1:1]};
        div_hi   = acc[2*XLEN-1:XLEN-1];
        div_ge   = div_hi >= {1'b0, opb};
        div_diff = div_hi[XLEN-1:0] - opb;
        div_next = {(div_ge ? div_diff : div_hi[XLEN-1:0]), acc[XLEN-2:0], div_ge};
    end

    // Sign correction, word select and special-case override.
    always_comb begin
        prod_fix = ctx.neg_q ? -acc : acc;
        quo_fix  = ctx.neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem_fix  = ctx.neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        if (ctx.op[2])
            fix_val = ctx.op[1] ? rem_fix : quo_fix;
        else if (ctx.op == OP_MUL)
            fix_val = prod_fix[XLEN-1:0];
        else
            fix_val = prod_fix[2*XLEN-1:XLEN];
        if (ctx.div0 || ctx.ovf)
            fix_val = md_special(ctx.op, ctx.div0, src_a);
    end

`ifdef MULDIV_FAST_PATH_EN
    logic [XLEN-1:0] fast_val;
    assign fast     = div0 | ovf | ((op_in == OP_MUL) && ((rs1 == '0) || (rs2 == '0)));
    assign fast_val = (op_in == OP_MUL) ? '0 : md_special(op_in, div0, rs1);
`else
    assign fast = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctx   <= '0;
            acc   <= '0;
            opb   <= '0;
            src_a <= '0;
        end else if (accept) begin
            ctx.op    <= op_in;
            ctx.neg_q <= sa ^ sb;
            ctx.neg_r <= sa;
            ctx.div0  <= div0;
            ctx.ovf   <= ovf;
            acc       <= {{XLEN{1'b0}}, abs_a};
            opb       <= abs_b;
            src_a     <= rs1;
        end else if (step) begin
            acc <= ctx.op[2] ? div_next : mul_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            result <= '0;
        else if (fix)
            result <= fix_val;
`ifdef MULDIV_FAST_PATH_EN
        else if (accept && fast)
            result <= fast_val;
`endif
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M multi-cycle sequencer: FSM, iteration counter and pipeline stall generation.
// MULDIV_FAST_PATH_EN (in the datapath) lets trivially-resolved ops jump straight to DONE.
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    md_state_e        state, state_next;
    logic [CNT_W-1:0] cnt;
    logic             accept, step, fix, fast;

    muldiv_sequencer_datapath u_datapath (
        .clk    (clk),
        .rst_n  (rst_n),
        .accept (accept),
        .step   (step),
        .fix    (fix),
        .op     (op_i),
        .rs1    (rs1_i),
        .rs2    (rs2_i),
        .fast   (fast),
        .result (result_o)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= MD_IDLE;
            cnt    <= '0;
            done_o <= 1'b0;
        end else begin
            state  <= state_next;
            done_o <= (state_next == MD_DONE);
            if (accept)
                cnt <= '0;
            else if (step)
                cnt <= cnt + CNT_W'(1);
        end
    end

    // Next state; stall is combinational so the hazard unit sees it in the accept cycle.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        step       = 1'b0;
        fix        = 1'b0;
        stall_o    = 1'b0;
        case (state)
            MD_IDLE: begin
                if (start_i && !flush_i) begin
                    accept  = 1'b1;
                    stall_o = 1'b1;
                    if (fast)
                        state_next = MD_DONE;
                    else
                        state_next = op_i[2] ? MD_DIV : MD_MUL;
                end
            end
            MD_MUL, MD_DIV: begin
                stall_o = 1'b1;
                step    = 1'b1;
                if (flush_i)
                    state_next = MD_IDLE;
                else if (cnt == CNT_W'(XLEN - 1))
                    state_next = MD_FIX;
            end
            MD_FIX: begin
                stall_o = 1'b1;
                if (flush_i) begin
                    state_next = MD_IDLE;
                end else begin
                    fix        = 1'b1;
                    state_next = MD_DONE;
                end
            end
            MD_DONE:  state_next = MD_IDLE;
            default:  state_next = MD_IDLE;
        endcase
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer; honours MULDIV_FAST_PATH_EN for latency.
module tb_muldiv_sequencer;

`ifdef MULDIV_FAST_PATH_EN
    localparam int FAST_LAT = 1;
`else
    localparam int FAST_LAT = 34;
`endif
    localparam int FULL_LAT = 34;

    logic        clk;
    logic        rst_n;
    logic        start_i;
    logic [2:0]  op_i;
    logic [31:0] rs1_i;
    logic [31:0] rs2_i;
    logic        flush_i;
    logic        stall_o;
    logic        done_o;
    logic [31:0] result_o;

    int checks   = 0;
    int failures = 0;

    muldiv_sequencer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (start_i),
        .op_i     (op_i),
        .rs1_i    (rs1_i),
        .rs2_i    (rs2_i),
        .flush_i  (flush_i),
        .stall_o  (stall_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Start an op at cycle 0, then watch until done_o (bounded) and check latency/stall/result.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res,
                          input int exp_lat, input bit noise);
        int lat;
        bit stall_ok;
        @(negedge clk);
        start_i = 1'b1;
        op_i    = op;
        rs1_i   = a;
        rs2_i   = b;
        #1;
        check_eq({tag, "_stall_c0"}, 32'(stall_o), 32'd1);
        @(posedge clk);
        #1;
        start_i  = 1'b0;
        lat      = 0;
        stall_ok = 1'b1;
        for (int c = 1; c <= 100 && lat == 0; c++) begin
            @(negedge clk);
            if (done_o) begin
                lat = c;
                check_eq({tag, "_stall_done"}, 32'(stall_o), 32'd0);
                check_eq({tag, "_res"}, result_o, exp_res);
            end else if (!stall_o) begin
                stall_ok = 1'b0;
            end
            if (noise && lat == 0 && c < 20) begin
                start_i = 1'b1;
                op_i    = 3'($urandom_range(0, 7));
                rs1_i   = $urandom;
                rs2_i   = $urandom;
            end else begin
                start_i = 1'b0;
            end
        end
        start_i = 1'b0;
        check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check_eq({tag, "_stall_busy"}, 32'(stall_ok), 32'd1);
    endtask

    initial begin
        bit early_done;
        rst_n   = 1'b0;
        start_i = 1'b0;
        flush_i = 1'b0;
        op_i    = 3'd0;
        rs1_i   = '0;
        rs2_i   = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_stall", 32'(stall_o), 32'd0);
        check_eq("rst_done", 32'(done_o), 32'd0);
        check_eq("rst_result", result_o, 32'd0);
        rst_n = 1'b1;

        run_op("mul_7xm3",      3'b000, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, FULL_LAT, 1'b0);
        run_op("mul_low",       3'b000, 32'h12345678,   32'h00000010, 32'h23456780, FULL_LAT, 1'b0);
        run_op("mulh_min",      3'b001, 32'h80000000,   32'h80000000, 32'h40000000, FULL_LAT, 1'b0);
        run_op("mulhu_ones",    3'b011, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, FULL_LAT, 1'b0);
        run_op("mulhsu_m1x2",   3'b010, 32'hFFFFFFFF,   32'd2,        32'hFFFFFFFF, FULL_LAT, 1'b0);
        run_op("mulhu_small",   3'b011, 32'h12345678,   32'h00000010, 32'h00000001, FULL_LAT, 1'b0);
        run_op("div_m7_2",      3'b100, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, FULL_LAT, 1'b0);
        run_op("rem_m7_2",      3'b110, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, FULL_LAT, 1'b0);
        run_op("divu_100_7",    3'b101, 32'd100,        32'd7,        32'd14,       FULL_LAT, 1'b0);
        run_op("remu_100_7",    3'b111, 32'd100,        32'd7,        32'd2,        FULL_LAT, 1'b0);

        // Flush in DIV at cycle 10: IDLE at 11, no done, result_o keeps 2.
        @(negedge clk);
        start_i = 1'b1; op_i = 3'b100; rs1_i = 32'd1000; rs2_i = 32'd3;
        @(posedge clk);
        #1;
        start_i    = 1'b0;
        early_done = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (done_o) early_done = 1'b1;
            if (c == 10) flush_i = 1'b1;
        end
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        @(negedge clk);
        check_eq("flush_stall_c11", 32'(stall_o), 32'd0);
        check_eq("flush_no_done", 32'(early_done | done_o), 32'd0);
        check_eq("flush_res_held", result_o, 32'd2);
        run_op("mul_after_flush", 3'b000, 32'd6, 32'd9, 32'd54, FULL_LAT, 1'b0);

        // start_i with flush_i in IDLE is not accepted.
        @(negedge clk);
        start_i = 1'b1; flush_i = 1'b1; op_i = 3'b101; rs1_i = 32'd9; rs2_i = 32'd3;
        #1;
        check_eq("idle_flush_stall", 32'(stall_o), 32'd0);
        @(posedge clk);
        #1;
        start_i = 1'b0; flush_i = 1'b0;
        @(negedge clk);
        check_eq("idle_flush_not_busy", 32'(stall_o | done_o), 32'd0);

        // Special cases: divide by zero and signed overflow.
        run_op("div_5_0",       3'b100, 32'd5,          32'd0,        32'hFFFFFFFF, FAST_LAT, 1'b0);
        run_op("rem_5_0",       3'b110, 32'd5,          32'd0,        32'd5,        FAST_LAT, 1'b0);
        run_op("div_m7_0",      3'b100, 32'hFFFFFFF9,   32'd0,        32'hFFFFFFFF, FAST_LAT, 1'b0);
        run_op("rem_m7_0",      3'b110, 32'hFFFFFFF9,   32'd0,        32'hFFFFFFF9, FAST_LAT, 1'b0);
        run_op("divu_5_0",      3'b101, 32'd5,          32'd0,        32'hFFFFFFFF, FAST_LAT, 1'b0);
        run_op("remu_x_0",      3'b111, 32'hFFFFFFF0,   32'd0,        32'hFFFFFFF0, FAST_LAT, 1'b0);
        run_op("div_ovf",       3'b100, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, FAST_LAT, 1'b0);
        run_op("rem_ovf",       3'b110, 32'h80000000,   32'hFFFFFFFF, 32'd0,        FAST_LAT, 1'b0);
        run_op("mul_zero",      3'b000, 32'd0,          32'd12345,    32'd0,        FAST_LAT, 1'b0);

        // start_i while busy must not disturb the op in flight.
        run_op("mulhu_noise",   3'b011, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, FULL_LAT, 1'b1);
        run_op("divu_noise",    3'b101, 32'd100,        32'd7,        32'd14,       FULL_LAT, 1'b1);

        // Asynchronous reset at cycle 20 of a DIV clears everything at once.
        @(negedge clk);
        start_i = 1'b1; op_i = 3'b100; rs1_i = 32'd1000; rs2_i = 32'd3;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        repeat (19) @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("arst_stall", 32'(stall_o), 32'd0);
        check_eq("arst_done", 32'(done_o), 32'd0);
        check_eq("arst_result", result_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("div_after_rst", 3'b100, 32'd1000, 32'd3, 32'd333, FULL_LAT, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
